// File: rtl/lcd_hsync_rx.sv
// lcd_hsync_rx: HSYNC receiver with period/width measurement,
// lock tracking and reconstructed active window / x-position.
//
// Ports:
//   lcd_clk      pixel clock
//   sys_rst_n    asynchronous active-low reset
//   lcd_hs_in    incoming HSYNC (synchronous to lcd_clk)
//   line_start   one-cycle pulse per detected leading edge
//   h_active     rebuilt active window (only while locked)
//   h_pos        active pixel index, 0 outside the window
//   meas_period  last lead-to-lead period
//   meas_width   last sync pulse width
//   locked       timing is stable
//   err_pulse    one-cycle pulse per bad event
//   err_cnt      saturating bad-event count
module lcd_hsync_rx #(
    parameter int H_SYNC      = 1,
    parameter int H_BACK      = 46,
    parameter int H_VALID     = 800,
    parameter int H_FRONT     = 210,
    parameter int HS_POL      = 1,
    parameter int LOCK_LINES  = 4,
    parameter int UNLOCK_ERRS = 2,
    parameter int CNT_W       = 12
) (
    input  logic             lcd_clk,
    input  logic             sys_rst_n,
    input  logic             lcd_hs_in,
    output logic             line_start,
    output logic             h_active,
    output logic [10:0]      h_pos,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_width,
    output logic             locked,
    output logic             err_pulse,
    output logic [7:0]       err_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;

    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] WIN_HI  =
        CNT_W'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [7:0] LOCK_C  = 8'(LOCK_LINES);
    localparam logic [7:0] UNLK_C  = 8'(UNLOCK_ERRS);
    localparam logic       POL_B   = 1'(HS_POL);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]       good_q;
    logic [7:0]       good_d;
    logic [7:0]       bad_q;
    logic [7:0]       bad_d;

    logic             a_q;
    logic             a_qq;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] wid_cnt;

    logic             lead;
    logic             trail;
    logic             hunting;
    logic             good_line;
    logic             timeout;
    logic             bad_evt;
    logic             in_win;
    logic [10:0]      pos_d;

    // Edge decode on the polarity-normalised sync.
    always_comb begin
        lead      = a_q & ~a_qq;
        trail     = ~a_q & a_qq;
        hunting   = (state_q != SEARCH);
        // meas_width still holds the previous pulse here.
        good_line = (per_cnt == TOTAL_C) &&
                    (meas_width == SYNC_C);
        // A lead in the same cycle takes precedence.
        timeout   = hunting && (per_cnt == TOTAL_C) && !lead;
        bad_evt   = hunting &&
                    ((lead && !good_line) || timeout);
    end

    // Window decode from the line counter.
    always_comb begin
        in_win = (per_cnt >= WIN_LO) && (per_cnt <= WIN_HI);
        pos_d  = '0;
        if (in_win) begin
            pos_d = 11'(per_cnt - WIN_LO);
        end
    end

    // Lock FSM: next state.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        unique case (state_q)
            SEARCH: begin
                if (lead) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (lead) begin
                    if (good_line) begin
                        good_d = good_q + 8'd1;
                        if (good_q + 8'd1 == LOCK_C) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d = SEARCH;
                end
            end
            LOCKED: begin
                if (lead && good_line) begin
                    bad_d = '0;
                end else if (bad_evt) begin
                    bad_d = bad_q + 8'd1;
                    if (bad_q + 8'd1 == UNLK_C) begin
                        state_d = SEARCH;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Lock FSM: state register.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= SEARCH;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    // Input sampling and edge history.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_q  <= 1'b0;
            a_qq <= 1'b0;
        end else begin
            a_q  <= ~(lcd_hs_in ^ POL_B);
            a_qq <= a_q;
        end
    end

    // Period counter with flywheel reload on timeout.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            per_cnt <= '0;
        end else if (lead || timeout) begin
            per_cnt <= CNT_W'(1);
        end else if (per_cnt != CNT_MAX) begin
            per_cnt <= per_cnt + CNT_W'(1);
        end
    end

    // Pulse width counter and captured measurements.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wid_cnt     <= '0;
            meas_width  <= '0;
            meas_period <= '0;
        end else begin
            if (lead) begin
                wid_cnt <= CNT_W'(1);
            end else if (a_q && (wid_cnt != CNT_MAX)) begin
                wid_cnt <= wid_cnt + CNT_W'(1);
            end
            if (trail) begin
                meas_width <= wid_cnt;
            end
            if (lead && hunting) begin
                meas_period <= per_cnt;
            end
        end
    end

    // Registered status and error outputs.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            line_start <= 1'b0;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
            locked     <= 1'b0;
        end else begin
            line_start <= lead;
            err_pulse  <= bad_evt;
            if (err_pulse && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            locked     <= (state_d == LOCKED);
        end
    end

    // Window follows the next state so it drops with lock.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_active <= 1'b0;
            h_pos    <= '0;
        end else if (state_d == LOCKED) begin
            h_active <= in_win;
            h_pos    <= pos_d;
        end else begin
            h_active <= 1'b0;
            h_pos    <= '0;
        end
    end

endmodule

// File: tb/tb_lcd_hsync_rx.sv
// tb_lcd_hsync_rx: directed bench for lcd_hsync_rx,
// active-high and active-low instances in parallel.
module tb_lcd_hsync_rx;

    logic        lcd_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        hs        = 1'b0;
    logic        hs_n;

    logic        ls_p, ha_p, lk_p, ep_p;
    logic [10:0] hp_p;
    logic [11:0] mp_p, mw_p;
    logic [7:0]  ec_p;

    logic        ls_n, ha_n, lk_n, ep_n;
    logic [10:0] hp_n;
    logic [11:0] mp_n, mw_n;
    logic [7:0]  ec_n;

    assign hs_n = ~hs;

    always #5 lcd_clk = ~lcd_clk;

    lcd_hsync_rx #(.HS_POL(1)) u_dut (
        .lcd_clk     (lcd_clk),
        .sys_rst_n   (sys_rst_n),
        .lcd_hs_in   (hs),
        .line_start  (ls_p),
        .h_active    (ha_p),
        .h_pos       (hp_p),
        .meas_period (mp_p),
        .meas_width  (mw_p),
        .locked      (lk_p),
        .err_pulse   (ep_p),
        .err_cnt     (ec_p)
    );

    lcd_hsync_rx #(.HS_POL(0)) u_dut_n (
        .lcd_clk     (lcd_clk),
        .sys_rst_n   (sys_rst_n),
        .lcd_hs_in   (hs_n),
        .line_start  (ls_n),
        .h_active    (ha_n),
        .h_pos       (hp_n),
        .meas_period (mp_n),
        .meas_width  (mw_n),
        .locked      (lk_n),
        .err_pulse   (ep_n),
        .err_cnt     (ec_n)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Generator state: period, pulse width, phase.
    int per = 1057;
    int wid = 1;
    int ph  = 0;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            hs = (ph < wid);
            ph = (ph + 1 >= per) ? 0 : ph + 1;
            @(posedge lcd_clk);
            #1;
        end
    endtask

    // Monitor state.
    int   cyc = 0;
    int   ls_cnt = 0, lock_ls = 0;
    int   lsn_cnt = 0, lock_ls_n = 0;
    int   n_err = 0, err_cyc = 0, err_prev = 0;
    int   ha_run = 0, last_run = 0, ha_tot = 0;
    int   pos_bad = 0, ls_cyc = 0, ls_to_ha = 0;
    logic lk_prev = 1'b0, lkn_prev = 1'b0, ha_prev = 1'b0;

    always @(negedge lcd_clk) begin
        cyc++;
        if (ls_p) begin
            ls_cnt++;
            ls_cyc = cyc;
        end
        if (lk_p && !lk_prev) lock_ls = ls_cnt;
        lk_prev = lk_p;
        if (ls_n) lsn_cnt++;
        if (lk_n && !lkn_prev) lock_ls_n = lsn_cnt;
        lkn_prev = lk_n;
        if (ep_p) begin
            n_err++;
            err_prev = err_cyc;
            err_cyc  = cyc;
        end
        if (ha_p) begin
            if (!ha_prev) ls_to_ha = cyc - ls_cyc;
            if (hp_p != 11'(ha_run)) pos_bad++;
            ha_run++;
            ha_tot++;
        end else begin
            if (ha_prev) last_run = ha_run;
            ha_run = 0;
            if (hp_p != 11'd0) pos_bad++;
        end
        ha_prev = ha_p;
    end

    int e0;
    int h0;

    initial begin
        repeat (3) @(posedge lcd_clk);
        #1;
        check("rst_meas", {8'd0, mp_p, mw_p}, 0);
        check("rst_misc", {9'd0, ls_p, ha_p, hp_p,
                           lk_p, ep_p, ec_p}, 0);
        check("rst_n_misc", {9'd0, ls_n, ha_n, hp_n,
                             lk_n, ep_n, ec_n}, 0);
        sys_rst_n = 1'b1;
        ls_cnt  = 0;
        lsn_cnt = 0;

        // Nominal lines.
        run(8 * 1057);
        check("lock_lead", lock_ls, 5);
        check("nom_locked", lk_p, 1);
        check("nom_period", mp_p, 1057);
        check("nom_width", mw_p, 1);
        check("nom_errcnt", ec_p, 0);
        check("nom_run", last_run, 800);
        check("nom_first_act", ls_to_ha, 47);
        check("pol0_lock_lead", lock_ls_n, 5);
        check("pol0_locked", lk_n, 1);
        check("pol0_period", mp_n, 1057);
        check("pol0_width", mw_n, 1);

        // One short line while locked.
        e0 = n_err;
        per = 1056;
        run(1056);
        per = 1057;
        run(1057);
        check("short_period", mp_p, 1056);
        check("short_nerr", n_err - e0, 1);
        check("short_locked", lk_p, 1);
        check("short_errcnt", ec_p, 1);
        run(2 * 1057);
        check("short_recover", mp_p, 1057);

        // Two short lines drop lock; then relock.
        per = 1056;
        run(2 * 1056);
        per = 1057;
        run(1057);
        check("short2_locked", lk_p, 0);
        check("short2_errcnt", ec_p, 3);
        run(5 * 1057);
        check("short2_relock", lk_p, 1);

        // Sync absent: flywheel then unlock.
        e0 = n_err;
        h0 = ha_tot;
        wid = 0;
        run(2214);
        check("idle_nerr", n_err - e0, 2);
        check("idle_gap", err_cyc - err_prev, 1057);
        check("idle_locked", lk_p, 0);
        check("idle_fly_act", ha_tot - h0, 800);
        check("idle_ha_end", ha_p, 0);
        check("idle_errcnt", ec_p, 5);
        ph  = 0;
        wid = 1;
        run(5 * 1057);
        check("idle_relock", lk_p, 1);
        check("idle_relock_ec", ec_p, 5);

        // Wide sync pulse.
        e0 = n_err;
        wid = 2;
        run(1057);
        check("wide_width", mw_p, 2);
        wid = 1;
        run(1057);
        check("wide_nerr", n_err - e0, 1);
        check("wide_locked", lk_p, 1);
        check("wide_errcnt", ec_p, 6);
        run(1057);
        wid = 2;
        run(2 * 1057);
        wid = 1;
        run(1057);
        check("wide2_locked", lk_p, 0);
        check("wide2_errcnt", ec_p, 8);
        run(5 * 1057);
        check("wide2_relock", lk_p, 1);

        // Asynchronous reset mid-window.
        run(300);
        check("pre_rst_act", ha_p, 1);
        check("pre_rst_pos", hp_p, 251);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_meas", {8'd0, mp_p, mw_p}, 0);
        check("arst_misc", {9'd0, ls_p, ha_p, hp_p,
                            lk_p, ep_p, ec_p}, 0);
        @(posedge lcd_clk);
        #1;
        run(5);
        sys_rst_n = 1'b1;
        ls_cnt    = 0;
        lsn_cnt   = 0;
        lock_ls   = 0;
        lock_ls_n = 0;
        run(per - ph);
        run(6 * 1057);
        check("rst_lock_lead", lock_ls, 5);
        check("rst_locked", lk_p, 1);
        check("rst_errcnt", ec_p, 0);
        check("rst_period", mp_p, 1057);
        check("rst_n_lock_lead", lock_ls_n, 5);
        check("rst_n_errcnt", ec_n, 0);
        check("pos_seq", pos_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
